poly_operand_driver: RTL

//  Drives the go/data_in operand-load protocol of poly_function. It stands in for the operator pressing KEY[1].

---
 rtl/poly_operand_driver_if.sv | 28 ++
 rtl/poly_operand_driver.sv | 127 ++++++++++++
 2 files changed

// File: rtl/poly_operand_driver_if.sv
// Operand-load bus between poly_operand_driver and its environment.
// The master side is the driver itself; the slave side is whoever issues
// start/operands and supplies data_result (poly_function or a test bench).
`timescale 1ns/1ps

interface poly_operand_driver_if;
   logic       start;
   logic [7:0] op_a;
   logic [7:0] op_b;
   logic [7:0] op_c;
   logic [7:0] op_x;
   logic [7:0] data_result;
   logic [7:0] data_out;
   logic       go;
   logic       busy;
   logic       done;
   logic [7:0] result;

   modport master (
      input  start, op_a, op_b, op_c, op_x, data_result,
      output data_out, go, busy, done, result
   );

   modport slave (
      output start, op_a, op_b, op_c, op_x, data_result,
      input  data_out, go, busy, done, result
   );
endinterface

// File: rtl/poly_operand_driver.sv
// poly_operand_driver: presses go once per operand (A, B, C, x) with timed
// setup/press/release phases, waits a fixed latency, then captures
// data_result and pulses done. All outputs are registered.
`timescale 1ns/1ps

module poly_operand_driver #(
   parameter int unsigned SETUP_CYC   = 2,
   parameter int unsigned PRESS_CYC   = 2,
   parameter int unsigned RELEASE_CYC = 2,
   parameter int unsigned RESULT_LAT  = 4
) (
   input  logic                  clk,
   input  logic                  resetn,
   poly_operand_driver_if.master bus
);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      PRESS,
      RELEASE,
      WAIT_RES,
      DONE
   } state_t;

   // Terminal counts: a timed state lasting N cycles leaves when cnt == N-1.
   localparam logic [7:0] SETUP_LAST   = 8'(SETUP_CYC - 1);
   localparam logic [7:0] PRESS_LAST   = 8'(PRESS_CYC - 1);
   localparam logic [7:0] RELEASE_LAST = 8'(RELEASE_CYC - 1);
   localparam logic [7:0] RESULT_LAST  = 8'(RESULT_LAT - 1);

   state_t          state;
   logic [7:0]      cnt;
   logic [1:0]      idx;
   logic [3:0][7:0] opnd;   // latched operands, index 0=A .. 3=x

   // Sequencer: state, counters and every output register move together so
   // go/data_out change on exactly the edge the state changes.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         // NOTE: the operand bank is a handful of flops, not a RAM, so it is
         // cleared with the rest of the state at no real cost.
         state        <= IDLE;
         cnt          <= '0;
         idx          <= '0;
         opnd         <= '0;
         bus.data_out <= '0;
         bus.go       <= 1'b0;
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
         bus.result   <= '0;
      end else begin
         // NOTE: done defaults low every cycle so it can only be a one-cycle
         // pulse; the DONE-entry branch below overrides it.
         bus.done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  opnd         <= {bus.op_x, bus.op_c, bus.op_b, bus.op_a};
                  idx          <= '0;
                  cnt          <= '0;
                  bus.data_out <= bus.op_a;
                  bus.busy     <= 1'b1;
                  state        <= SETUP;
               end
            end
            SETUP: begin
               if (cnt == SETUP_LAST) begin
                  cnt    <= '0;
                  bus.go <= 1'b1;
                  state  <= PRESS;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            PRESS: begin
               if (cnt == PRESS_LAST) begin
                  cnt    <= '0;
                  bus.go <= 1'b0;
                  state  <= RELEASE;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            RELEASE: begin
               if (cnt == RELEASE_LAST) begin
                  cnt <= '0;
                  if (idx == 2'd3) begin
                     bus.data_out <= '0;
                     state        <= WAIT_RES;
                  end else begin
                     idx          <= idx + 2'd1;
                     bus.data_out <= opnd[idx + 2'd1];
                     state        <= SETUP;
                  end
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            WAIT_RES: begin
               if (cnt == RESULT_LAST) begin
                  cnt        <= '0;
                  bus.result <= bus.data_result;
                  bus.done   <= 1'b1;
                  state      <= DONE;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            DONE: begin
               // start is not sampled here, so a held start re-launches one
               // edge after the return to IDLE.
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               state        <= IDLE;
               cnt          <= '0;
               bus.go       <= 1'b0;
               bus.busy     <= 1'b0;
               bus.data_out <= '0;
            end
         endcase
      end
   end

endmodule
